// File: rtl/biu_constants_pkg.sv
// biu_constants_pkg: bus transfer size encoding; a transfer moves 2^size bytes.
package biu_constants_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;
endpackage

// File: rtl/riscv_state_pkg.sv
// riscv_state_pkg: privilege levels, PMP configuration layout and access-fault cause codes.
package riscv_state_pkg;
    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_M = 2'd3;

    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    localparam logic [3:0] CAUSE_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_LOAD_ACCESS_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_ACCESS_FAULT = 4'd7;

    typedef struct packed {
        logic       l;
        logic [1:0] rsv;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;
endpackage

// File: rtl/riscv_pmp_decode.sv
// riscv_pmp_decode: turns one pmpcfg/pmpaddr pair into a word-granular [lb, ub) range.
module riscv_pmp_decode
    import riscv_state_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PLEN     = 34,
    parameter int PMP_GRAN = 0
) (
    input  pmpcfg_t         cfg,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] prev_addr,
    input  logic [PLEN-3:0] prev_ub,
    input  logic            prev_tor,
    output logic [PLEN-3:0] lb,
    output logic [PLEN-3:0] ub
);
    localparam int AW = PLEN - 2;
    localparam logic [AW-1:0] GMASK = (AW'(1) << PMP_GRAN) - AW'(1);
    localparam logic [AW-1:0] NMASK = GMASK >> 1;

    logic [AW-1:0] tor_a, napot_a, mask, base;
    logic [AW:0]   sum;
    int            t;
    logic          unused_ok;

    assign unused_ok = ^{cfg, addr, prev_addr};

    always_comb begin
        tor_a   = AW'(addr) & ~GMASK;
        napot_a = AW'(addr) | NMASK;
        t = AW;
        for (int k = AW - 1; k >= 0; k--) if (!napot_a[k]) t = k;
        // shifting by >= AW yields 0, so the all-ones address gives a full-space mask
        mask = (cfg.a == A_NA4) ? '0 : (AW'(1) << (t + 1)) - AW'(1);
        base = napot_a & ~mask;
        sum  = {1'b0, base} + {1'b0, mask} + (AW + 1)'(1);
        lb = '0;
        ub = tor_a;
        if (cfg.a == A_TOR) begin
            lb = prev_tor ? AW'(prev_addr) & ~GMASK : prev_ub;
        end else if (cfg.a == A_NAPOT || (cfg.a == A_NA4 && PMP_GRAN == 0)) begin
            lb = base;
            ub = sum[AW] ? '1 : sum[AW-1:0];
        end
    end
endmodule

// File: rtl/riscv_pmpchk_pipe.sv
// riscv_pmpchk_pipe: PMP access checker with a sequentially refreshed bounds table
// and a one-cycle registered result.
module riscv_pmpchk_pipe
    import riscv_state_pkg::*;
    import biu_constants_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PLEN     = XLEN == 32 ? 34 : 56,
    parameter int PMP_CNT  = 16,
    parameter int PMP_GRAN = 0
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_i,
    input  pmpcfg_t [(PMP_CNT > 0 ? PMP_CNT : 1)-1:0]            st_pmpcfg_i,
    input  logic    [(PMP_CNT > 0 ? PMP_CNT : 1)-1:0][XLEN-1:0] st_pmpaddr_i,
    input  logic [1:0]                                           st_prv_i,
    input  logic                                                 st_pmp_update_i,
    input  logic                                                 req_i,
    input  logic                                                 instruction_i,
    input  logic [PLEN-1:0]                                      adr_i,
    input  biu_size_t                                            size_i,
    input  logic                                                 we_i,
    input  logic                                                 stall_i,
    output logic                                                 ready_o,
    output logic                                                 valid_o,
    output logic                                                 exception_o,
    output logic [3:0]                                           cause_o,
    output logic [5:0]                                           match_idx_o
);
    localparam int CNT = PMP_CNT > 0 ? PMP_CNT : 1;
    localparam int IW  = CNT > 1 ? $clog2(CNT) : 1;
    localparam int TAB = 2 ** IW;
    localparam int AW  = PLEN - 2;

    typedef enum logic {REFRESH, IDLE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n, pidx, w;
    pmpcfg_t         cfg [TAB];
    logic [XLEN-1:0] paddr [TAB];
    logic [AW-1:0]   lb_tab [TAB];
    logic [AW-1:0]   ub_tab [TAB];
    logic [AW-1:0]   dec_lb, dec_ub, prev_ub, lo, hi;
    logic [XLEN-1:0] prev_addr;
    logic            prev_tor, hit, perm_bad, fault, unused_ok;
    logic [PLEN-1:0] last;
    logic [3:0]      cause;
    int              win;

    // pad to a power of two so idx always addresses a real row
    for (genvar g = 0; g < TAB; g++) begin : g_pad
        if (g < CNT) begin : g_on
            assign cfg[g]   = st_pmpcfg_i[g];
            assign paddr[g] = st_pmpaddr_i[g];
        end else begin : g_off
            assign cfg[g]   = '0;
            assign paddr[g] = '0;
        end
    end

    assign pidx      = idx - IW'(1);
    assign prev_addr = idx == '0 ? '0 : paddr[pidx];
    assign prev_ub   = idx == '0 ? '0 : ub_tab[pidx];
    assign prev_tor  = idx != '0 && cfg[pidx].a == A_TOR;

    riscv_pmp_decode #(.XLEN(XLEN), .PLEN(PLEN), .PMP_GRAN(PMP_GRAN)) u_dec (
        .cfg       (cfg[idx]),
        .addr      (paddr[idx]),
        .prev_addr (prev_addr),
        .prev_ub   (prev_ub),
        .prev_tor  (prev_tor),
        .lb        (dec_lb),
        .ub        (dec_ub)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (state == REFRESH) begin
            idx_n = idx + IW'(1);
            if (idx == IW'(CNT - 1)) begin
                state_n = IDLE;
                idx_n   = '0;
            end
        end
        if (st_pmp_update_i && PMP_CNT > 0) begin
            state_n = REFRESH;
            idx_n   = '0;
        end
    end

    assign ready_o = PMP_CNT == 0 ? ~stall_i : state == IDLE && !st_pmp_update_i && !stall_i;

    always_ff @(posedge clk_i)
        if (state == REFRESH) begin
            lb_tab[idx] <= dec_lb;
            ub_tab[idx] <= dec_ub;
        end

    always_comb begin
        last = adr_i + ((PLEN'(1) << size_i) - PLEN'(1));
        lo   = adr_i[PLEN-1:2];
        hi   = last[PLEN-1:2];
        hit  = 1'b0;
        win  = 0;
        for (int i = PMP_CNT - 1; i >= 0; i--)
            if ((cfg[i].a == A_TOR || cfg[i].a == A_NAPOT || (cfg[i].a == A_NA4 && PMP_GRAN == 0))
                && lo < ub_tab[i] && hi >= lb_tab[i]) begin
                hit = 1'b1;
                win = i;
            end
        w = IW'(win);
        perm_bad = (st_prv_i != PRV_M || cfg[w].l) &&
                   (instruction_i ? !cfg[w].x : we_i ? !cfg[w].w : !cfg[w].r);
        fault = hit ? (lo < lb_tab[w] || hi >= ub_tab[w] || perm_bad)
                    : (st_prv_i != PRV_M && PMP_CNT > 0);
        cause = !fault ? 4'd0 : instruction_i ? CAUSE_INSTR_ACCESS_FAULT :
                we_i ? CAUSE_STORE_ACCESS_FAULT : CAUSE_LOAD_ACCESS_FAULT;
    end

    assign unused_ok = ^last[1:0];

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state       <= PMP_CNT > 0 ? REFRESH : IDLE;
            idx         <= '0;
            valid_o     <= 1'b0;
            exception_o <= 1'b0;
            cause_o     <= '0;
            match_idx_o <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (req_i && ready_o) begin
                valid_o     <= 1'b1;
                exception_o <= fault;
                cause_o     <= cause;
                match_idx_o <= 6'(win);
            end else if (!stall_i) begin
                valid_o     <= 1'b0;
                exception_o <= 1'b0;
                cause_o     <= '0;
                match_idx_o <= '0;
            end
        end
endmodule

// File: doc/riscv_pmpchk_pipe.md
RISCV_PMPCHK_PIPE -- requirements
Module: riscv_pmpchk_pipe

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- XLEN, 32, integer register width.
- PLEN, XLEN==32 ? 34 : 56, physical address width.
- PMP_CNT, 16, number of implemented PMP entries, 0..64.
- PMP_GRAN, 0, PMP granularity G; regions are 2^(G+2) bytes.

REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk_i, in, 1, the single clock.
- rst_i, in, 1, reset, asynchronous, active-high.
- st_pmpcfg_i, in, pmpcfg_t[PMP_CNT], PMP configuration entries.
- st_pmpaddr_i, in, [PMP_CNT][XLEN], PMP address registers.
- st_prv_i, in, 2, current privilege level.
- st_pmp_update_i, in, 1, pulse: some pmpcfg/pmpaddr was written.
- req_i, in, 1, access request.
- instruction_i, in, 1, the access is an instruction fetch.
- adr_i, in, PLEN, physical address.
- size_i, in, biu_size_t, transfer size.
- we_i, in, 1, write access.
- stall_i, in, 1, downstream stall; holds the result register.
- ready_o, out, 1, bounds table valid and request accepted.
- valid_o, out, 1, result valid.
- exception_o, out, 1, access fault.
- cause_o, out, 4, exception cause code.
- match_idx_o, out, 6, index of the matched entry.

Function
REQ-003 A registered bounds table (lb[i], ub[i], PLEN-2 bits each) SHALL hold the decoded range of every entry.
REQ-004 The FSM SHALL have two states:
- REFRESH: each cycle computes entry idx; idx increments; at idx==PMP_CNT-1 it moves to IDLE.
- IDLE: table valid; a full refresh takes exactly PMP_CNT cycles.
REQ-005 st_pmp_update_i SHALL force REFRESH with idx=0 on the next cycle, from either state, including mid-refresh.
REQ-006 In REFRESH, the bounds for entry i SHALL be decoded as follows:
- TOR: lb = (i==0 ? 0 : table ub[i-1] when cfg[i-1].a!=TOR, else pmpaddr[i-1]); ub = pmpaddr[i].
- NAPOT: trailing ones in pmpaddr plus one give n; lb = addr & ~(2^n-1); ub = lb + 2^n.
- NA4: as NAPOT with n=0.
- OFF: the entry never matches.
REQ-007 Granularity rules SHALL apply when PMP_GRAN>=1: NA4 is treated as OFF, and pmpaddr[G-1:0] reads as 0 for TOR; when PMP_GRAN>=2, NAPOT pmpaddr[G-2:0] reads as all ones.
REQ-008 ready_o SHALL be (state==IDLE) & ~st_pmp_update_i & ~stall_i; a request is accepted when req_i & ready_o.
REQ-009 Acceptance timing SHALL be:
- An accepted request produces valid_o=1 exactly one cycle later (latency 1).
- With no acceptance and ~stall_i, valid_o goes to 0 on the next cycle.
- With stall_i=1, valid_o, exception_o, cause_o and match_idx_o hold.
REQ-010 Matching SHALL use access range [adr_i, adr_i+bytes-1] compared on bits [PLEN-1:2].
- An entry matches if any byte falls in [lb, ub).
- The lowest matching index wins; match_idx_o holds that index, else 0.
REQ-011 exception_o SHALL be set when any of the following holds:
- (a) the winning entry does not contain all bytes;
- (b) (st_prv_i!=PRV_M | cfg.l) and an R/W/X permission check fails;
- (c) no entry matches, st_prv_i!=PRV_M and PMP_CNT>0.
REQ-012 cause_o SHALL be 1 for an instruction fetch, 7 for a write, 5 for a read, and 0 when exception_o=0.
REQ-013 With PMP_CNT==0, the FSM SHALL stay in IDLE, ready_o SHALL follow ~stall_i, and exception_o SHALL never assert.
REQ-014 A result already in the output register when an update arrives SHALL complete unchanged, evaluated against the old table.
REQ-015 All arithmetic SHALL be unsigned PLEN-2 bits; a NAPOT ub overflowing past the top SHALL saturate to all ones.

Reset
REQ-016 rst_i SHALL force state=REFRESH, idx=0, valid_o=0, exception_o=0, cause_o=0, match_idx_o=0; table contents are don't-care until the refresh completes.
REQ-017 ready_o SHALL be 0 from reset until PMP_CNT cycles after rst_i deasserts.

Structure
REQ-018 pmpcfg_t, the A-field encodings (OFF/TOR/NA4/NAPOT), PRV_* and the cause codes SHALL come from riscv_state_pkg; biu_size_t SHALL come from biu_constants_pkg.
REQ-019 The per-entry bound decode SHALL be a sub-module riscv_pmp_decode (cfg, addr, prev_ub, prev_tor -> lb, ub), instantiated once and shared by the refresh FSM.

Verification
REQ-020 Reset, then hold rst_i low for 16 cycles -> ready_o=0 during cycles 1..16 and 1 at cycle 17.
REQ-021 Entry 0 NAPOT pmpaddr=0x0000_01FF (4KiB at 0x0), cfg r=1 w=0 x=0, prv=U:
- 4-byte write to 0x100 -> next cycle valid_o=1, exception_o=1, cause_o=7.
- 4-byte read -> exception_o=0, match_idx_o=0.
REQ-022 Entry 0 TOR pmpaddr=0x400 (lb 0, ub 0x1000), rwx=1, prv=S:
- 8-byte read at 0xFFC -> exception_o=1 (partial match).
- 8-byte read at 0xFF8 -> exception_o=0.
REQ-023 Pulse st_pmp_update_i at refresh cycle 5 -> idx restarts, ready_o rises 16 cycles after the pulse; a request held on req_i is accepted only then.
REQ-024 stall_i=1 for 3 cycles after a faulting result -> valid_o, exception_o and cause_o hold and ready_o=0; release -> next request completes in 1 cycle.
REQ-025 PMP_CNT=0, prv=U, any access -> exception_o=0 and valid_o one cycle after each accepted request.
